alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Consumer end of the ALU result interface: takes the registered instruction_t and 32-bit result produced each cycle by the ALU and drives the register-file write port.
- Buffers results in a small FIFO so a stalled write port (wb_ready low) does not lose ALU results.
- Raises stall back toward issue, and flags overflow if an in-flight result arrives with no space.
- Sits between the EX lane and the register file, one instance per ALU lane.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >= 2).
- REG_ADDR_W, 5, register-file address width; must match the rd field width of instruction_t.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- inst_in  input  instruction_t  instruction from the ALU; uses the opcode and rd fields.
- result_in  input  32  ALU result paired with inst_in.
- stall  output  1  high when count >= DEPTH-1; issue must not send a new ALU op.
- wb_valid  output  1  head entry is presented on the write port.
- wb_rd  output  REG_ADDR_W  destination register of the head entry.
- wb_data  output  32  data of the head entry.
- wb_ready  input  1  register file accepts the write this cycle.
- overflow  output  1  sticky: a writing result arrived while the FIFO was full.

Behaviour:
- Reset (rst low, asynchronous): pointers and count = 0; wb_valid = 0, wb_rd = 0, wb_data = 0, stall = 0, overflow = 0. Reset asserted mid-operation discards every buffered entry; nothing is written after reset releases.
- A write request exists when inst_in.opcode is ADD, SUB, AND, OR or XOR and inst_in.rd != 0.
  - Any other opcode, including the all-zero bubble, is ignored.
  - rd == 0 is ignored, because r0 is hardwired.
- Push: a write request pushes {rd, result_in} at the rising edge.
- Pop: occurs when wb_valid && wb_ready.
- Output timing:
  - wb_valid/wb_rd/wb_data are driven from the head entry.
  - wb_valid = (count != 0).
  - An entry pushed at edge N is visible from edge N onward; the minimum latency is one cycle after the ALU result appears.
  - There is no combinational pass-through.
- Order: entries retire strictly in push order.
- Simultaneous push and pop:
  - count is unchanged.
  - The pushed entry is allowed even when count == DEPTH, because the pop frees the slot.
- Push when count == DEPTH without a pop: the entry is dropped, overflow is set, and count stays at DEPTH. overflow clears only on reset.
- stall is registered-count based: stall = (count >= DEPTH-1). This leaves room for the one op already inside the ALU pipeline stage.
- Empty boundary: a pop cannot occur when count == 0, because wb_valid is 0.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- wb_rd/wb_data are don't-care while wb_valid = 0; the implementation holds the last head values.

Optional Feature:
- Macro: MEGAVLIW_WB_FWD_EN.
- With the macro defined, the block adds three ports:
  - fwd_rd (input, REG_ADDR_W)
  - fwd_hit (output, 1)
  - fwd_data (output, 32)
- Forwarding lookup rules:
  - The lookup is combinational over all valid FIFO entries.
  - When several entries match fwd_rd, the youngest one wins.
  - fwd_rd == 0 always gives fwd_hit = 0.
  - The lookup does not see the entry being pushed in the same cycle.
  - During reset, fwd_hit = 0 and fwd_data = 0.
- Without the macro, none of these ports or the comparison logic exist.

Decomposition:
- Shared package cpu_defs holds:
  - instruction_t, with the rd field of width REG_ADDR_W
  - the opcode enum (ADD, SUB, AND, OR, XOR)
  - REG_ADDR_W
  - a wb_entry_t struct {rd, data}
- One sub-module is natural: wb_fifo, a generic DEPTH-deep FIFO of wb_entry_t with push, pop, count and a per-entry visibility vector for the forwarding lookup.
- alu_writeback wraps wb_fifo with request decode, stall, overflow and forwarding.

Test Plan:
- Reset then ADD rd=3 result=0x0000_0005, wb_ready=1 -> wb_valid=1, wb_rd=3, wb_data=5 one cycle later, then wb_valid=0.
- Bubble (opcode=0) and XOR with rd=0 -> wb_valid stays 0 and count stays 0.
- wb_ready=0, push 3 ops (rd=1,2,3) -> stall rises after the 3rd push (count=3, DEPTH=4). Release wb_ready -> writes rd 1,2,3 in order, and stall falls when count=2.
- Fill to 4 with wb_ready=0, push a 5th -> overflow=1, entry dropped. Repeat at count=4 with wb_ready=1 -> push and pop both succeed, count stays 4, overflow unchanged.
- Assert rst low asynchronously mid-drain with count=3 -> outputs zero immediately, and nothing is written after release.
- MEGAVLIW_WB_FWD_EN: buffer rd=7 data=0xA, then rd=7 data=0xB, then query fwd_rd=7 -> fwd_hit=1, fwd_data=0xB. Query fwd_rd=0 -> fwd_hit=0.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_defs
// Description : Instruction, opcode and write-back entry types shared by the
//               ALU write-back slice.
// Revision    : 1.0
// ============================================================================
package cpu_defs;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    ADD    = 4'd1,
    SUB    = 4'd2,
    AND    = 4'd3,
    OR     = 4'd4,
    XOR    = 4'd5
  } opcode_e;

  typedef struct packed {
    opcode_e                opcode;
    logic [REG_ADDR_W-1:0]  rd;
    logic [REG_ADDR_W-1:0]  rs1;
    logic [REG_ADDR_W-1:0]  rs2;
    logic [11:0]            imm;
  } instruction_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]  rd;
    logic [DATA_W-1:0]      data;
  } wb_entry_t;

  // r0 is hardwired, so a write to it is never a real request.
  function automatic logic writes_reg(input instruction_t inst);
    return (inst.opcode inside {ADD, SUB, AND, OR, XOR}) && (inst.rd != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_writeback_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : DEPTH-deep FIFO of write-back entries with an age-ordered view
//               of every slot (oldest first) for lookups.
// Revision    : 1.0
// ============================================================================
module wb_fifo
  import cpu_defs::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  output wb_entry_t               head,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output wb_entry_t [DEPTH-1:0]   age_entry,
  output logic [DEPTH-1:0]        age_valid
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pop_ok, push_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign age_entry[k] = mem_q[rd_ptr_q + PTR_W'(k)];
    assign age_valid[k] = (CNT_W'(k) < count_q);
  end

endmodule
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
// Module      : alu_writeback
// Description : Buffers ALU results and drives the register-file write port;
//               MEGAVLIW_WB_FWD_EN adds a youngest-match forwarding lookup.
// Revision    : 1.0
// ============================================================================
module alu_writeback
  import cpu_defs::*;
#(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = cpu_defs::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  instruction_t          inst_in,
  input  logic [31:0]           result_in,
  output logic                  stall,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [31:0]           wb_data,
  input  logic                  wb_ready,
  output logic                  overflow
`ifdef MEGAVLIW_WB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0] fwd_rd,
  output logic                  fwd_hit,
  output logic [31:0]           fwd_data
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t             push_entry, head;
  wb_entry_t [DEPTH-1:0] age_entry;
  logic [DEPTH-1:0]      age_valid;
  logic [CNT_W-1:0]      count;
  logic                  full, push_req, pop;
  logic                  overflow_q, overflow_d;

  assign push_req   = writes_reg(inst_in);
  assign push_entry = '{rd: inst_in.rd, data: result_in};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_req),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .age_entry  (age_entry),
    .age_valid  (age_valid)
  );

  assign wb_valid = (count != '0);
  assign pop      = wb_valid && wb_ready;
  assign wb_rd    = head.rd;
  assign wb_data  = head.data;
  // One slot of headroom covers the op already inside the ALU stage.
  assign stall    = (count >= CNT_W'(DEPTH - 1));

  always_comb begin
    overflow_d = overflow_q;
    if (push_req && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

`ifdef MEGAVLIW_WB_FWD_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_valid[k] && (fwd_rd != '0) && (age_entry[k].rd == fwd_rd)) begin
        fwd_hit  = 1'b1;
        fwd_data = age_entry[k].data;
      end
    end
  end

  logic unused_inst;
  assign unused_inst = ^{inst_in.rs1, inst_in.rs2, inst_in.imm};
`else
  logic unused_inst;
  assign unused_inst = ^{inst_in.rs1, inst_in.rs2, inst_in.imm, age_entry, age_valid};
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_writeback
// Description : Directed scoreboard bench for alu_writeback.
// Revision    : 1.0
// ============================================================================
module tb_alu_writeback;
  import cpu_defs::*;

  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  instruction_t          inst_in;
  logic [31:0]           result_in;
  logic                  stall, wb_valid, wb_ready, overflow;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [31:0]           wb_data;
`ifdef MEGAVLIW_WB_FWD_EN
  logic [REG_ADDR_W-1:0] fwd_rd;
  logic                  fwd_hit;
  logic [31:0]           fwd_data;
`endif

  int        checks = 0;
  int        errors = 0;
  wb_entry_t exp_q[$];

  always #5 clk = ~clk;

  alu_writeback #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_in   (inst_in),
    .result_in (result_in),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .overflow  (overflow)
`ifdef MEGAVLIW_WB_FWD_EN
    ,
    .fwd_rd    (fwd_rd),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input opcode_e op, input logic [4:0] rd, input logic [31:0] data,
                       input bit exp_push);
    wb_entry_t e;
    inst_in        = '0;
    inst_in.opcode = op;
    inst_in.rd     = rd;
    result_in      = data;
    if (exp_push) begin
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: a write retires at the next rising edge whenever valid && ready mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", wb_rd, wb_data);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data) begin
          errors++;
          $display("FAIL write_order: got rd=%0d data=%h, expected rd=%0d data=%h",
                   wb_rd, wb_data, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    wb_ready  = 1'b0;
    inst_in   = '0;
    result_in = '0;
`ifdef MEGAVLIW_WB_FWD_EN
    fwd_rd    = '0;
`endif
    repeat (3) tick();
    check("rst_valid", wb_valid, 0);
    check("rst_rd", wb_rd, 0);
    check("rst_data", wb_data, 0);
    check("rst_stall", stall, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    tick();

    // Single write: visible one edge after issue, gone after it retires.
    wb_ready = 1'b1;
    issue(ADD, 5'd3, 32'h0000_0005, 1);
    #1;
    check("t1_no_passthru", wb_valid, 0);
    tick();
    issue(OP_NOP, 5'd0, 32'h0, 0);
    check("t1_valid", wb_valid, 1);
    check("t1_rd", wb_rd, 3);
    check("t1_data", wb_data, 5);
    tick();
    check("t1_drained", wb_valid, 0);

    // Non-writing traffic.
    issue(OP_NOP, 5'd5, 32'h11, 0);
    tick();
    check("bubble_valid", wb_valid, 0);
    issue(XOR, 5'd0, 32'h22, 0);
    tick();
    issue(OP_NOP, 5'd0, 32'h0, 0);
    check("r0_valid", wb_valid, 0);
    check("r0_stall", stall, 0);

    // Stall threshold at count = DEPTH-1.
    wb_ready = 1'b0;
    issue(ADD, 5'd1, 32'h101, 1); tick();
    check("stall_c1", stall, 0);
    issue(SUB, 5'd2, 32'h202, 1); tick();
    check("stall_c2", stall, 0);
    issue(AND, 5'd3, 32'h303, 1); tick();
    check("stall_c3", stall, 1);
    check("stall_head_rd", wb_rd, 1);
    issue(OP_NOP, 5'd0, 32'h0, 0);
    wb_ready = 1'b1;
    tick();
    check("stall_fall_c2", stall, 0);
    tick(); tick();
    check("stall_drained", wb_valid, 0);

    // Full FIFO: drop without pop, accept with pop.
    wb_ready = 1'b0;
    issue(OR,  5'd4, 32'h404, 1); tick();
    issue(XOR, 5'd5, 32'h505, 1); tick();
    issue(ADD, 5'd6, 32'h606, 1); tick();
    issue(SUB, 5'd7, 32'h707, 1); tick();
    check("full_stall", stall, 1);
    check("full_no_ovf", overflow, 0);
    issue(ADD, 5'd8, 32'h808, 0); tick();
    check("ovf_set", overflow, 1);
    check("ovf_head_rd", wb_rd, 4);
    wb_ready = 1'b1;
    issue(ADD, 5'd9, 32'h909, 1); tick();
    issue(OP_NOP, 5'd0, 32'h0, 0);
    check("pushpop_stall", stall, 1);
    check("pushpop_ovf", overflow, 1);
    check("pushpop_head_rd", wb_rd, 5);
    repeat (3) tick();
    check("pushpop_c4_valid", wb_valid, 1);
    tick();
    check("pushpop_drained", wb_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Asynchronous reset mid-drain discards everything buffered.
    wb_ready = 1'b0;
    issue(ADD, 5'd10, 32'hA0A, 1); tick();
    issue(ADD, 5'd11, 32'hB0B, 1); tick();
    issue(ADD, 5'd12, 32'hC0C, 1); tick();
    issue(ADD, 5'd13, 32'hD0D, 1); tick();
    issue(OP_NOP, 5'd0, 32'h0, 0);
    wb_ready = 1'b1;
    tick();
    #1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("arst_valid", wb_valid, 0);
    check("arst_rd", wb_rd, 0);
    check("arst_data", wb_data, 0);
    check("arst_stall", stall, 0);
    check("arst_overflow", overflow, 0);
`ifdef MEGAVLIW_WB_FWD_EN
    fwd_rd = 5'd11;
    #1;
    check("arst_fwd_hit", fwd_hit, 0);
    check("arst_fwd_data", fwd_data, 0);
    fwd_rd = '0;
`endif
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("post_rst_valid", wb_valid, 0);

`ifdef MEGAVLIW_WB_FWD_EN
    // Forwarding: youngest match wins; same-cycle push is not visible.
    wb_ready = 1'b0;
    issue(ADD, 5'd7, 32'hA, 1); tick();
    issue(OR,  5'd7, 32'hB, 1); tick();
    issue(XOR, 5'd2, 32'hC, 1);
    fwd_rd = 5'd2;
    #1;
    check("fwd_same_cycle_hit", fwd_hit, 0);
    tick();
    issue(OP_NOP, 5'd0, 32'h0, 0);
    fwd_rd = 5'd7;
    #1;
    check("fwd_young_hit", fwd_hit, 1);
    check("fwd_young_data", fwd_data, 32'hB);
    fwd_rd = 5'd2;
    #1;
    check("fwd_rd2_hit", fwd_hit, 1);
    check("fwd_rd2_data", fwd_data, 32'hC);
    fwd_rd = 5'd0;
    #1;
    check("fwd_r0_hit", fwd_hit, 0);
    fwd_rd = 5'd9;
    #1;
    check("fwd_miss_hit", fwd_hit, 0);
    wb_ready = 1'b1;
    repeat (3) tick();
    check("fwd_drained", wb_valid, 0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d writes pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
